rv_ctl_mc: RTL and testbench

- Next-generation control plane for the multicycle RISC-V core. It drives the same datapath control set as the current controller.
- Adds a memory ready handshake with wait states, a parametrised wait timeout, and a trap state.
- Extends the decoded instructions to I-ALU, JALR, LUI and optional BNE/BLT/BGE.
- Adds a retired-instruction counter.

---
 rtl/rv_ctl_mc.sv | 235 +++++++++++++++++++++++
 tb/tb_rv_ctl_mc.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_ctl_mc.sv
// Multicycle RISC-V control FSM: drives the datapath enables/selects, waits on a memory ready
// handshake with a bounded timeout, traps on illegal opcodes, and counts retired instructions.
module rv_ctl_mc #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned TIMEOUT   = 15,
  parameter bit          EN_BR_EXT = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [31:0]      instr_i,
  input  logic             zero_i,
  input  logic             lt_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             memrw_o,
  output logic [1:0]       pcsource_o,
  output logic             pcwrite_o,
  output logic             pccen_o,
  output logic             irwrite_o,
  output logic             mdrwrite_o,
  output logic             regwen_o,
  output logic [1:0]       wbsel_o,
  output logic [2:0]       immsel_o,
  output logic             asel_o,
  output logic             bsel_o,
  output logic [3:0]       alusel_o,
  output logic             trap_o,
  output logic [1:0]       trap_cause_o,
  output logic [CNT_W-1:0] instret_o
);

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAddr, StMemRd, StMemWb, StMemWr, StRAlu, StIAlu,
    StAluWb, StBrExec, StJalExec, StJalrExec, StLuiWb, StTrap
  } state_e;

  localparam logic [3:0] AluAdd   = 4'b0000;
  localparam logic [3:0] AluSub   = 4'b0001;
  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             mem_req;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_lw, is_sw, is_r, is_ialu, is_br, is_jal, is_jalr, is_lui, br_ok, br_take;
  logic       wait_hit;
  logic       unused_instr;

  assign opcode       = instr_i[6:0];
  assign funct3       = instr_i[14:12];
  assign unused_instr = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};

  assign is_lw   = (opcode == 7'b0000011) && (funct3 == 3'b010);
  assign is_sw   = (opcode == 7'b0100011) && (funct3 == 3'b010);
  assign is_r    = (opcode == 7'b0110011);
  assign is_ialu = (opcode == 7'b0010011);
  assign is_br   = (opcode == 7'b1100011) && br_ok;
  assign is_jal  = (opcode == 7'b1101111);
  assign is_jalr = (opcode == 7'b1100111) && (funct3 == 3'b000);
  assign is_lui  = (opcode == 7'b0110111);

  always_comb begin
    br_ok   = 1'b0;
    br_take = 1'b0;
    case (funct3)
      3'b000: begin br_ok = 1'b1;      br_take = zero_i;  end
      3'b001: begin br_ok = EN_BR_EXT; br_take = !zero_i; end
      3'b100: begin br_ok = EN_BR_EXT; br_take = lt_i;    end
      3'b101: begin br_ok = EN_BR_EXT; br_take = !lt_i;   end
      default: ;
    endcase
  end

  assign wait_hit = (wait_q == WaitLast);

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    mem_req    = 1'b0;
    memrw_o    = 1'b0;
    pcsource_o = 2'b00;
    pcwrite_o  = 1'b0;
    pccen_o    = 1'b0;
    irwrite_o  = 1'b0;
    mdrwrite_o = 1'b0;
    regwen_o   = 1'b0;
    wbsel_o    = 2'b00;
    immsel_o   = 3'b000;
    asel_o     = 1'b0;
    bsel_o     = 1'b0;
    alusel_o   = AluAdd;
    unique case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ready_i) begin
          irwrite_o = 1'b1;
          pcwrite_o = 1'b1;
          pccen_o   = 1'b1;
          state_d   = StDecode;
        end else if (wait_hit) begin
          state_d = StTrap;
          cause_d = 2'b10;
        end
      end
      StDecode: begin
        // ALUOut captures the PC-relative branch/jump target here
        asel_o   = 1'b1;
        bsel_o   = 1'b1;
        immsel_o = is_jal ? 3'b011 : 3'b010;
        if (is_lw || is_sw) state_d = StMemAddr;
        else if (is_r)      state_d = StRAlu;
        else if (is_ialu)   state_d = StIAlu;
        else if (is_br)     state_d = StBrExec;
        else if (is_jal)    state_d = StJalExec;
        else if (is_jalr)   state_d = StJalrExec;
        else if (is_lui)    state_d = StLuiWb;
        else begin
          state_d = StTrap;
          cause_d = 2'b01;
        end
      end
      StMemAddr: begin
        bsel_o   = 1'b1;
        immsel_o = is_sw ? 3'b001 : 3'b000;
        state_d  = is_sw ? StMemWr : StMemRd;
      end
      StMemRd: begin
        mem_req    = 1'b1;
        mdrwrite_o = mem_ready_i;
        if (mem_ready_i) begin
          state_d = StMemWb;
        end else if (wait_hit) begin
          state_d = StTrap;
          cause_d = 2'b10;
        end
      end
      StMemWb: begin
        wbsel_o  = 2'b10;
        regwen_o = 1'b1;
        state_d  = StFetch;
      end
      StMemWr: begin
        mem_req = 1'b1;
        memrw_o = 1'b1;
        if (mem_ready_i) begin
          state_d = StFetch;
        end else if (wait_hit) begin
          state_d = StTrap;
          cause_d = 2'b10;
        end
      end
      StRAlu: begin
        alusel_o = {funct3, instr_i[30]};
        state_d  = StAluWb;
      end
      StIAlu: begin
        // Only SRLI/SRAI use bit 30 as a modifier; elsewhere it is immediate data
        bsel_o   = 1'b1;
        alusel_o = {funct3, (funct3 == 3'b101) ? instr_i[30] : 1'b0};
        state_d  = StAluWb;
      end
      StAluWb: begin
        wbsel_o  = 2'b01;
        regwen_o = 1'b1;
        state_d  = StFetch;
      end
      StBrExec: begin
        alusel_o   = AluSub;
        pcsource_o = 2'b01;
        pcwrite_o  = br_take;
        state_d    = StFetch;
      end
      StJalExec: begin
        pcsource_o = 2'b01;
        pcwrite_o  = 1'b1;
        regwen_o   = 1'b1;
        state_d    = StFetch;
      end
      StJalrExec: begin
        bsel_o     = 1'b1;
        pcsource_o = 2'b10;
        pcwrite_o  = 1'b1;
        regwen_o   = 1'b1;
        state_d    = StFetch;
      end
      StLuiWb: begin
        immsel_o = 3'b100;
        wbsel_o  = 2'b11;
        regwen_o = 1'b1;
        state_d  = StFetch;
      end
      StTrap: ;
      default: state_d = StFetch;
    endcase
  end

  always_comb begin
    wait_d    = wait_q;
    instret_d = instret_q;
    if (state_d != state_q) begin
      wait_d = 8'd0;
    end else if ((state_q == StFetch || state_q == StMemRd || state_q == StMemWr) &&
                 !mem_ready_i) begin
      wait_d = wait_q + 8'd1;
    end
    if (state_d == StFetch && state_q != StFetch) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StFetch;
      wait_q    <= 8'd0;
      cause_q   <= 2'b00;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  // Reset state is FETCH, but a request must not be seen while reset is held
  assign mem_req_o    = mem_req & rst_ni;
  assign trap_o       = (state_q == StTrap);
  assign trap_cause_o = cause_q;
  assign instret_o    = instret_q;

endmodule

// File: tb/tb_rv_ctl_mc.sv
// Directed bench for rv_ctl_mc: one default-parameter instance (A) and one with CNT_W=4,
// TIMEOUT=4, EN_BR_EXT=0 (B). Control outputs are compared as a packed word.
module tb_rv_ctl_mc;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  logic        a_rst_n, a_zero, a_lt, a_ready;
  logic [31:0] a_instr;
  logic        a_mem_req, a_memrw, a_pcwrite, a_pccen, a_irwrite, a_mdrwrite, a_regwen;
  logic        a_asel, a_bsel, a_trap;
  logic [1:0]  a_pcsource, a_wbsel, a_cause;
  logic [2:0]  a_immsel;
  logic [3:0]  a_alusel;
  logic [31:0] a_instret;
  logic [19:0] a_ctl;

  logic        b_rst_n, b_zero, b_lt, b_ready;
  logic [31:0] b_instr;
  logic        b_mem_req, b_memrw, b_pcwrite, b_pccen, b_irwrite, b_mdrwrite, b_regwen;
  logic        b_asel, b_bsel, b_trap;
  logic [1:0]  b_pcsource, b_wbsel, b_cause;
  logic [2:0]  b_immsel;
  logic [3:0]  b_alusel;
  logic [3:0]  b_instret;
  logic [19:0] b_ctl;

  rv_ctl_mc u_dut_a (
    .clk_i(clk), .rst_ni(a_rst_n), .instr_i(a_instr), .zero_i(a_zero), .lt_i(a_lt),
    .mem_ready_i(a_ready), .mem_req_o(a_mem_req), .memrw_o(a_memrw), .pcsource_o(a_pcsource),
    .pcwrite_o(a_pcwrite), .pccen_o(a_pccen), .irwrite_o(a_irwrite), .mdrwrite_o(a_mdrwrite),
    .regwen_o(a_regwen), .wbsel_o(a_wbsel), .immsel_o(a_immsel), .asel_o(a_asel),
    .bsel_o(a_bsel), .alusel_o(a_alusel), .trap_o(a_trap), .trap_cause_o(a_cause),
    .instret_o(a_instret)
  );

  rv_ctl_mc #(.CNT_W(4), .TIMEOUT(4), .EN_BR_EXT(1'b0)) u_dut_b (
    .clk_i(clk), .rst_ni(b_rst_n), .instr_i(b_instr), .zero_i(b_zero), .lt_i(b_lt),
    .mem_ready_i(b_ready), .mem_req_o(b_mem_req), .memrw_o(b_memrw), .pcsource_o(b_pcsource),
    .pcwrite_o(b_pcwrite), .pccen_o(b_pccen), .irwrite_o(b_irwrite), .mdrwrite_o(b_mdrwrite),
    .regwen_o(b_regwen), .wbsel_o(b_wbsel), .immsel_o(b_immsel), .asel_o(b_asel),
    .bsel_o(b_bsel), .alusel_o(b_alusel), .trap_o(b_trap), .trap_cause_o(b_cause),
    .instret_o(b_instret)
  );

  assign a_ctl = {a_mem_req, a_memrw, a_pcsource, a_pcwrite, a_pccen, a_irwrite, a_mdrwrite,
                  a_regwen, a_wbsel, a_immsel, a_asel, a_bsel, a_alusel};
  assign b_ctl = {b_mem_req, b_memrw, b_pcsource, b_pcwrite, b_pccen, b_irwrite, b_mdrwrite,
                  b_regwen, b_wbsel, b_immsel, b_asel, b_bsel, b_alusel};

  function automatic logic [19:0] cw(input logic mreq, input logic mrw, input logic [1:0] pcs,
                                     input logic pcw, input logic pcc, input logic irw,
                                     input logic mdrw, input logic rwen, input logic [1:0] wb,
                                     input logic [2:0] imm, input logic as, input logic bs,
                                     input logic [3:0] alu);
    return {mreq, mrw, pcs, pcw, pcc, irw, mdrw, rwen, wb, imm, as, bs, alu};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step_a(input string tag, input logic [19:0] exp);
    #1 chk(tag, {12'd0, a_ctl}, {12'd0, exp});
    @(negedge clk);
  endtask

  task automatic step_b(input string tag, input logic [19:0] exp);
    #1 chk(tag, {12'd0, b_ctl}, {12'd0, exp});
    @(negedge clk);
  endtask

  localparam logic [31:0] IAdd  = 32'h002081B3;
  localparam logic [31:0] ISrai = 32'h4010D093;
  localparam logic [31:0] IAddi = 32'h40008093;
  localparam logic [31:0] ILw   = 32'h0000A103;
  localparam logic [31:0] ISw   = 32'h0020A023;
  localparam logic [31:0] IBeq  = 32'h00208463;
  localparam logic [31:0] IBne  = 32'h00209463;
  localparam logic [31:0] IBlt  = 32'h0020C463;
  localparam logic [31:0] IBge  = 32'h0020D463;
  localparam logic [31:0] IJal  = 32'h008000EF;
  localparam logic [31:0] IJalr = 32'h000080E7;
  localparam logic [31:0] ILui  = 32'h123450B7;

  logic [19:0] f0, f1, dec_b, dec_j, ma_i, ma_s, rd0, rd1, mwb, wr, awb;
  logic [19:0] br1, br0, jal_e, jalr_e, lui_e, idle;

  initial begin
    f0     = cw(1, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 4'b0000);
    f1     = cw(1, 0, 2'b00, 1, 1, 1, 0, 0, 2'b00, 3'b000, 0, 0, 4'b0000);
    dec_b  = cw(0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 3'b010, 1, 1, 4'b0000);
    dec_j  = cw(0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 3'b011, 1, 1, 4'b0000);
    ma_i   = cw(0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 1, 4'b0000);
    ma_s   = cw(0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 3'b001, 0, 1, 4'b0000);
    rd0    = cw(1, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 4'b0000);
    rd1    = cw(1, 0, 2'b00, 0, 0, 0, 1, 0, 2'b00, 3'b000, 0, 0, 4'b0000);
    mwb    = cw(0, 0, 2'b00, 0, 0, 0, 0, 1, 2'b10, 3'b000, 0, 0, 4'b0000);
    wr     = cw(1, 1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 4'b0000);
    awb    = cw(0, 0, 2'b00, 0, 0, 0, 0, 1, 2'b01, 3'b000, 0, 0, 4'b0000);
    br1    = cw(0, 0, 2'b01, 1, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 4'b0001);
    br0    = cw(0, 0, 2'b01, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 4'b0001);
    jal_e  = cw(0, 0, 2'b01, 1, 0, 0, 0, 1, 2'b00, 3'b000, 0, 0, 4'b0000);
    jalr_e = cw(0, 0, 2'b10, 1, 0, 0, 0, 1, 2'b00, 3'b000, 0, 1, 4'b0000);
    lui_e  = cw(0, 0, 2'b00, 0, 0, 0, 0, 1, 2'b11, 3'b100, 0, 0, 4'b0000);
    idle   = 20'd0;

    a_rst_n = 1'b0; a_instr = IAdd; a_zero = 1'b0; a_lt = 1'b0; a_ready = 1'b0;
    b_rst_n = 1'b0; b_instr = ILui; b_zero = 1'b0; b_lt = 1'b0; b_ready = 1'b0;
    #1;
    chk("a_rst_ctl", {12'd0, a_ctl}, 32'd0);
    chk("a_rst_trap", {30'd0, a_trap, a_cause[0]}, 32'd0);
    chk("a_rst_cause", {30'd0, a_cause}, 32'd0);
    chk("a_rst_instret", a_instret, 32'd0);
    @(negedge clk);
    a_rst_n = 1'b1;

    // R-type ADD, ready tied high
    a_ready = 1'b1;
    step_a("add_fetch", f1);
    step_a("add_decode", dec_b);
    step_a("add_ralu", cw(0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 4'b0000));
    step_a("add_wb", awb);
    chk("add_instret", a_instret, 32'd1);

    a_instr = ISrai;
    step_a("srai_fetch", f1);
    step_a("srai_decode", dec_b);
    step_a("srai_ialu", cw(0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 1, 4'b1011));
    step_a("srai_wb", awb);

    a_instr = IAddi;
    step_a("addi_fetch", f1);
    step_a("addi_decode", dec_b);
    step_a("addi_ialu", cw(0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 1, 4'b0000));
    step_a("addi_wb", awb);
    chk("addi_instret", a_instret, 32'd3);

    // LW with three wait cycles in MEM_RD
    a_instr = ILw;
    step_a("lw_fetch", f1);
    step_a("lw_decode", dec_b);
    step_a("lw_addr", ma_i);
    a_ready = 1'b0;
    step_a("lw_rd_wait0", rd0);
    step_a("lw_rd_wait1", rd0);
    step_a("lw_rd_wait2", rd0);
    a_ready = 1'b1;
    step_a("lw_rd_ready", rd1);
    step_a("lw_wb", mwb);
    chk("lw_instret", a_instret, 32'd4);

    a_instr = IBne; a_zero = 1'b0;
    step_a("bne_fetch", f1);
    step_a("bne_decode", dec_b);
    step_a("bne_taken", br1);
    a_instr = IBne; a_zero = 1'b1;
    step_a("bne2_fetch", f1);
    step_a("bne2_decode", dec_b);
    step_a("bne_not_taken", br0);
    a_instr = IBlt; a_lt = 1'b1;
    step_a("blt_fetch", f1);
    step_a("blt_decode", dec_b);
    step_a("blt_taken", br1);
    a_instr = IBge;
    step_a("bge_fetch", f1);
    step_a("bge_decode", dec_b);
    step_a("bge_not_taken", br0);
    a_instr = IBeq;
    step_a("beq_fetch", f1);
    step_a("beq_decode", dec_b);
    step_a("beq_taken", br1);
    chk("br_instret", a_instret, 32'd9);

    a_instr = IJal;
    step_a("jal_fetch", f1);
    step_a("jal_decode", dec_j);
    step_a("jal_exec", jal_e);
    a_instr = IJalr;
    step_a("jalr_fetch", f1);
    step_a("jalr_decode", dec_b);
    step_a("jalr_exec", jalr_e);
    a_instr = ILui;
    step_a("lui_fetch", f1);
    step_a("lui_decode", dec_b);
    step_a("lui_wb", lui_e);
    chk("jmp_instret", a_instret, 32'd12);

    // Ready arriving on the last allowed wait cycle must not trap
    a_ready = 1'b0;
    for (int i = 0; i < 14; i++) step_a("tmo_edge_wait", f0);
    a_ready = 1'b1;
    step_a("tmo_edge_ready", f1);
    chk("tmo_edge_notrap", {31'd0, a_trap}, 32'd0);
    step_a("tmo_edge_decode", dec_b);
    step_a("tmo_edge_lui", lui_e);

    a_instr = 32'hFFFFFFFF;
    step_a("ill_fetch", f1);
    step_a("ill_decode", dec_b);
    step_a("ill_trap_ctl", idle);
    chk("ill_trap", {31'd0, a_trap}, 32'd1);
    chk("ill_cause", {30'd0, a_cause}, 32'd1);
    step_a("ill_trap_hold", idle);
    chk("ill_instret", a_instret, 32'd13);

    // Instance B: timeout of 4 in FETCH
    b_rst_n = 1'b1; b_ready = 1'b0;
    for (int i = 0; i < 4; i++) step_b("b_tmo_fetch", f0);
    step_b("b_tmo_ctl", idle);
    chk("b_tmo_trap", {31'd0, b_trap}, 32'd1);
    chk("b_tmo_cause", {30'd0, b_cause}, 32'd2);
    b_ready = 1'b1;
    step_b("b_tmo_hold", idle);
    chk("b_tmo_instret", {28'd0, b_instret}, 32'd0);

    b_rst_n = 1'b0;
    #1 chk("b_rst_trap", {31'd0, b_trap}, 32'd0);
    chk("b_rst_cause", {30'd0, b_cause}, 32'd0);
    @(negedge clk);
    b_rst_n = 1'b1;
    b_instr = IBne;
    step_b("b_bne_fetch", f1);
    step_b("b_bne_decode", dec_b);
    step_b("b_bne_trap", idle);
    chk("b_bne_cause", {30'd0, b_cause}, 32'd1);

    b_rst_n = 1'b0;
    @(negedge clk);
    b_rst_n = 1'b1;
    b_instr = IBeq; b_zero = 1'b1;
    step_b("b_beq_fetch", f1);
    step_b("b_beq_decode", dec_b);
    step_b("b_beq_taken", br1);
    b_instr = ILui;
    for (int i = 0; i < 14; i++) begin
      step_b("b_lui_fetch", f1);
      step_b("b_lui_decode", dec_b);
      step_b("b_lui_wb", lui_e);
    end
    chk("b_instret_15", {28'd0, b_instret}, 32'd15);
    step_b("b_wrap_fetch", f1);
    step_b("b_wrap_decode", dec_b);
    step_b("b_wrap_wb", lui_e);
    chk("b_instret_wrap", {28'd0, b_instret}, 32'd0);
    step_b("b_post_fetch", f1);
    step_b("b_post_decode", dec_b);
    step_b("b_post_wb", lui_e);
    chk("b_instret_1", {28'd0, b_instret}, 32'd1);

    // Reset asserted mid-store
    b_instr = ISw;
    step_b("b_sw_fetch", f1);
    step_b("b_sw_decode", dec_b);
    step_b("b_sw_addr", ma_s);
    b_ready = 1'b0;
    #1 chk("b_sw_memwr", {12'd0, b_ctl}, {12'd0, wr});
    #1 b_rst_n = 1'b0;
    #1 chk("b_rst_memreq", {31'd0, b_mem_req}, 32'd0);
    chk("b_rst_instret", {28'd0, b_instret}, 32'd0);
    @(negedge clk);
    b_rst_n = 1'b1;
    step_b("b_rst_fetch", f0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
